// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the RV32M divide unit
package div_pkg;
   localparam int DATA_W = 32;
   localparam int ITERS  = 32;
   localparam int CNT_W  = 5;

   localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [DATA_W-1:0] INT_MIN   = 32'h8000_0000;

   typedef enum logic [1:0] {
      FN_DIV  = 2'b00,
      FN_DIVU = 2'b01,
      FN_REM  = 2'b10,
      FN_REMU = 2'b11
   } funct_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration on the {remainder, quotient} pair
module div_step
   import div_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);
   logic [W:0]   shifted;
   logic [W-1:0] diff;
   logic         fits;

   // The shifted remainder can exceed W bits, so the trial compare is W+1 wide.
   assign shifted  = {rem, quo[W-1]};
   assign fits     = (shifted >= {1'b0, divisor});
   assign diff     = shifted[W-1:0] - divisor;
   assign rem_next = fits ? diff : shifted[W-1:0];
   assign quo_next = {quo[W-2:0], fits};
endmodule

// File: rtl/divide_extension.sv
// rtl/divide_extension.sv - iterative RV32M DIV/DIVU/REM/REMU unit; DIV_EARLY_OUT_EN skips CALC for div-by-zero and overflow
module divide_extension #(
   parameter int DATA_W = div_pkg::DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_op_a,
   input  logic [DATA_W-1:0] i_op_b,
   input  logic [1:0]        i_funct,
   output logic              o_busy,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_result
);
   import div_pkg::*;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

   state_e            state, state_next;
   logic [CNT_W-1:0]  count;
   funct_e            funct_q;
   logic              sign_a, sign_b, div_zero, overflow;
   logic [DATA_W-1:0] a_q, divisor_q, rem_q, quo_q;
   logic [DATA_W-1:0] rem_step, quo_step;

   logic              signed_in, zero_in, overflow_in;
   logic [DATA_W-1:0] mag_a, mag_b;

   assign signed_in   = ~i_funct[0];
   assign mag_a       = (signed_in && i_op_a[DATA_W-1]) ? -i_op_a : i_op_a;
   assign mag_b       = (signed_in && i_op_b[DATA_W-1]) ? -i_op_b : i_op_b;
   assign zero_in     = (i_op_b == '0);
   assign overflow_in = signed_in && (i_op_a == INT_MIN) && (i_op_b == '1);

   div_step #(.W(DATA_W)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (divisor_q),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
`ifdef DIV_EARLY_OUT_EN
               state_next = (zero_in || overflow_in) ? ST_DONE : ST_CALC;
`else
               state_next = ST_CALC;
`endif
            end
         end
         ST_CALC: if (count == LAST_ITER) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign o_busy = (state != ST_IDLE);

   logic              is_rem;
   logic [DATA_W-1:0] quo_fix, rem_fix, result;

   // Special cases override whatever the datapath produced.
   always_comb begin
      is_rem  = (funct_q == FN_REM) || (funct_q == FN_REMU);
      quo_fix = (funct_q == FN_DIV && sign_a != sign_b) ? -quo_q : quo_q;
      rem_fix = (funct_q == FN_REM && sign_a) ? -rem_q : rem_q;
      if (div_zero)      result = is_rem ? a_q : DIV0_QUOT;
      else if (overflow) result = is_rem ? '0 : INT_MIN;
      else               result = is_rem ? rem_fix : quo_fix;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count     <= '0;
         funct_q   <= FN_DIV;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
         a_q       <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         o_valid   <= 1'b0;
         o_result  <= '0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  funct_q   <= funct_e'(i_funct);
                  sign_a    <= signed_in & i_op_a[DATA_W-1];
                  sign_b    <= signed_in & i_op_b[DATA_W-1];
                  div_zero  <= zero_in;
                  overflow  <= overflow_in;
                  a_q       <= i_op_a;
                  divisor_q <= mag_b;
                  rem_q     <= '0;
                  quo_q     <= mag_a;
                  count     <= '0;
               end
            end
            ST_CALC: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               count <= count + 1'b1;
            end
            ST_DONE: begin
               o_result <= result;
               o_valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/divide_extension.md
DIVIDE_EXTENSION -- requirements
Module: divide_extension

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port i_op_a  input  32  dividend.
REQ-006 SHALL have port i_op_b  input  32  divisor.
REQ-007 SHALL have port i_funct  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of the RV32M divide group).
REQ-008 SHALL have port o_busy  output  1  high while a request is in flight (CALC or DONE).
REQ-009 SHALL have port o_valid  output  1  one-cycle completion strobe.
REQ-010 SHALL have port o_result  output  32  quotient or remainder; holds its value until the next completion.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-012 IDLE with i_start=1 SHALL:
  - latch i_funct;
  - latch the magnitudes of both operands (signed ops only), the sign of each operand, and the special-case flags;
  - clear the iteration counter;
  - go to CALC.
REQ-013 CALC SHALL perform one restoring step per cycle:
  - shift the {remainder, quotient} pair left by one;
  - trial-subtract |b|;
  - keep the difference and set the quotient bit when no borrow occurs.
REQ-014 CALC SHALL run exactly 32 iterations, then go to DONE.
REQ-015 DONE SHALL:
  - register the sign-corrected result into o_result;
  - assert o_valid for exactly one cycle;
  - return to IDLE.
REQ-016 Nominal latency SHALL be: o_valid high in the cycle beginning 33 edges after the edge that sampled i_start.
REQ-017 Sign correction SHALL be:
  - quotient negated when the op is DIV and sign_a != sign_b;
  - remainder negated when the op is REM and sign_a = 1;
  - unsigned ops never negated.
REQ-018 Divide by zero (i_op_b = 0) SHALL give:
  - DIV and DIVU: 0xFFFFFFFF;
  - REM and REMU: i_op_a unchanged.
REQ-019 Signed overflow (DIV or REM with i_op_a = 0x80000000 and i_op_b = 0xFFFFFFFF) SHALL give:
  - DIV: 0x80000000;
  - REM: 0x00000000.
REQ-020 i_start asserted while o_busy = 1 SHALL be ignored, with no queuing and no effect on the current request.
REQ-021 A new i_start SHALL be accepted in the IDLE cycle that immediately follows DONE.
REQ-022 Operand inputs SHALL be don't-care after the sampling edge.
REQ-023 o_busy SHALL be high from the cycle after the sampling edge through the DONE cycle inclusive.

Reset
REQ-024 While i_rst_n = 0, asynchronously and at any point including mid-CALC, the block SHALL hold:
  - FSM = IDLE;
  - counter = 0;
  - o_busy = 0, o_valid = 0, o_result = 0x00000000.
REQ-025 A request interrupted by reset SHALL be discarded and SHALL never produce o_valid.

Configuration
REQ-026 With macro DIV_EARLY_OUT_EN defined, divide-by-zero and signed-overflow requests SHALL bypass CALC: IDLE to DONE directly, o_valid high in the cycle beginning 1 edge after sampling.
REQ-027 Without DIV_EARLY_OUT_EN, those cases SHALL run the full 32 CALC cycles (same latency as REQ-016), with the REQ-018/REQ-019 values overriding the datapath result in DONE.
REQ-028 Results SHALL be identical with and without DIV_EARLY_OUT_EN; only latency differs.

Structure
REQ-029 Package div_pkg SHALL hold:
  - DATA_W;
  - the funct encoding enum (DIV, DIVU, REM, REMU);
  - the FSM state enum;
  - the constants DIV0_QUOT = 0xFFFFFFFF and INT_MIN = 0x80000000.
REQ-030 The single restoring iteration SHALL be a combinational sub-module div_step, taking remainder, quotient and divisor and returning the next remainder and quotient.
REQ-031 No other sub-modules are required.

Verification
REQ-032 DIVU 100/7 -> o_result 0x0000000E at 33 cycles; REMU 100/7 -> 0x00000002.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 0x00000001.
REQ-034 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - Latency 1 cycle with DIV_EARLY_OUT_EN, 33 cycles without.
REQ-035 DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; a second i_start pulsed mid-CALC -> ignored, exactly one o_valid, first result unchanged.
REQ-036 Reset asserted at CALC cycle 10 -> o_busy, o_valid, o_result all 0 immediately.
  - No o_valid afterwards.
  - A fresh DIVU 9/3 then returns 0x00000003.
REQ-037 Back-to-back: i_start in the cycle after o_valid -> accepted; the second result arrives with the nominal latency.
